// File: rtl/rc4_pkg.sv
// RC4 PRGA engine package: FSM state encoding and default plaintext filter bounds.
package rc4_pkg;

    localparam int unsigned CHAR_LO_DEF    = 97;
    localparam int unsigned CHAR_HI_DEF    = 122;
    localparam int unsigned CHAR_EXTRA_DEF = 32;

    typedef enum logic [3:0] {
        StIdle,
        StIncI,
        StRdSi,
        StRdSj,
        StWrSi,
        StWrSj,
        StRdF,
        StWrite,
        StDone
    } state_e;

    // True when a decrypted byte is within the accepted plaintext alphabet.
    function automatic logic char_ok(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi, input int unsigned extra);
        return ((v >= lo) && (v <= hi)) || (v == extra);
    endfunction

endpackage

// File: rtl/rc4_prga_engine.sv
// RC4 keystream generator / decryptor: walks the S RAM one byte per 7 cycles and writes
// ciphertext XOR keystream into the answer RAM.
// Optional plaintext rejection is enabled by defining RC4_PLAINTEXT_CHECK_EN.
module rc4_prga_engine
    import rc4_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned S_ADDR_W   = 8,
    parameter int unsigned MSG_ADDR_W = 5,
    parameter int unsigned CHAR_LO    = CHAR_LO_DEF,
    parameter int unsigned CHAR_HI    = CHAR_HI_DEF,
    parameter int unsigned CHAR_EXTRA = CHAR_EXTRA_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MSG_ADDR_W:0]   msg_len,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic [S_ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic                  s_wren,
    input  logic [DATA_W-1:0]     k_rdata,
    output logic [MSG_ADDR_W-1:0] k_addr,
    output logic [MSG_ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0]     a_wdata,
    output logic                  a_wren,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic [MSG_ADDR_W-1:0] fail_idx
);

`ifdef RC4_PLAINTEXT_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    localparam logic [S_ADDR_W-1:0]   SOne   = S_ADDR_W'(1);
    localparam logic [MSG_ADDR_W-1:0] KOne   = MSG_ADDR_W'(1);
    localparam logic [MSG_ADDR_W:0]   LenOne = (MSG_ADDR_W + 1)'(1);

    state_e                state_q;
    logic [S_ADDR_W-1:0]   i_q, j_q;
    logic [DATA_W-1:0]     si_q, sj_q;
    logic [MSG_ADDR_W-1:0] k_q, fail_idx_q;
    logic [MSG_ADDR_W:0]   len_q;
    logic                  success_q;

    logic [S_ADDR_W-1:0]   j_sum, f_addr;
    logic [DATA_W-1:0]     pt;
    logic                  reject, last_byte, busy_int;

    // Datapath helpers: new j, keystream address, decrypted byte and its verdict.
    always_comb begin
        j_sum     = j_q + S_ADDR_W'(s_rdata);
        f_addr    = S_ADDR_W'(si_q) + S_ADDR_W'(sj_q);
        pt        = s_rdata ^ k_rdata;
        reject    = CheckEn && !char_ok(32'(pt), CHAR_LO, CHAR_HI, CHAR_EXTRA);
        last_byte = ({1'b0, k_q} == (len_q - LenOne));
        busy_int  = (state_q != StIdle) && (state_q != StDone);
    end

    // Control FSM and per-byte state registers; abort preempts every busy state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            len_q      <= '0;
            fail_idx_q <= '0;
            success_q  <= 1'b0;
        end else if (abort && busy_int) begin
            state_q   <= StIdle;
            success_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        fail_idx_q <= '0;
                        if (msg_len != '0) begin
                            len_q     <= msg_len;
                            i_q       <= '0;
                            j_q       <= '0;
                            k_q       <= '0;
                            success_q <= 1'b0;
                            state_q   <= StIncI;
                        end else begin
                            success_q <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StIncI: begin
                    i_q     <= i_q + SOne;
                    state_q <= StRdSi;
                end
                StRdSi: begin
                    si_q    <= s_rdata;
                    j_q     <= j_sum;
                    state_q <= StRdSj;
                end
                StRdSj: begin
                    sj_q    <= s_rdata;
                    state_q <= StWrSi;
                end
                StWrSi:  state_q <= StWrSj;
                StWrSj:  state_q <= StRdF;
                StRdF:   state_q <= StWrite;
                StWrite: begin
                    if (reject) begin
                        success_q  <= 1'b0;
                        fail_idx_q <= k_q;
                        state_q    <= StDone;
                    end else if (last_byte) begin
                        success_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        k_q     <= k_q + KOne;
                        state_q <= StIncI;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory-port decode; write enables are gated by abort in the same cycle.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        a_wdata = '0;
        a_wren  = 1'b0;
        unique case (state_q)
            StIncI: s_addr = i_q + SOne;
            StRdSi: s_addr = j_sum;
            StWrSi: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = !abort;
            end
            StWrSj: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = !abort;
            end
            StRdF:  s_addr = f_addr;
            StWrite: begin
                a_wdata = pt;
                a_wren  = !abort;
            end
            default: ;
        endcase
    end

    assign k_addr   = k_q;
    assign a_addr   = k_q;
    assign busy     = busy_int;
    assign done     = (state_q == StDone);
    assign success  = success_q;
    assign fail_idx = CheckEn ? fail_idx_q : '0;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Self-checking bench for rc4_prga_engine with behavioural RC4 reference model.
// Expectations follow RC4_PLAINTEXT_CHECK_EN when the bench is built with it.
module tb_rc4_prga_engine;

`ifdef RC4_PLAINTEXT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] msg_len = '0;
    logic [7:0] s_rdata, k_rdata;
    logic [7:0] s_addr, s_wdata, a_wdata;
    logic [4:0] k_addr, a_addr, fail_idx;
    logic       s_wren, a_wren, busy, done, success;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rc4_prga_engine dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .msg_len  (msg_len),
        .s_rdata  (s_rdata),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wren   (s_wren),
        .k_rdata  (k_rdata),
        .k_addr   (k_addr),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_wren   (a_wren),
        .busy     (busy),
        .done     (done),
        .success  (success),
        .fail_idx (fail_idx)
    );

    // Synchronous memories around the DUT
    logic [7:0] s_ram  [256];
    logic [7:0] s_init [256];
    logic [7:0] k_rom  [32];
    logic [7:0] a_ram  [32];
    logic       load = 1'b0;
    int         s_wr_cnt = 0, a_wr_cnt = 0, done_cnt = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) s_ram[x] <= s_init[x];
        end else if (s_wren) begin
            s_ram[s_addr] <= s_wdata;
        end
        s_rdata <= s_ram[s_addr];
        k_rdata <= k_rom[k_addr];
        if (a_wren) a_ram[a_addr] <= a_wdata;
        if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
        if (a_wren) a_wr_cnt <= a_wr_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    // Reference model state
    logic [7:0] m_s [256];
    logic [7:0] exp_a [32];
    int         ks [32];
    bit         exp_success;
    int         exp_fail, exp_bytes;

    function automatic bit ok_char(input int v);
        return ((v >= 97) && (v <= 122)) || (v == 32);
    endfunction

    // Plain RC4 PRGA over a copy of the model S-box; commit=0 is a keystream preview.
    task automatic model_run(input int len, input bit commit);
        logic [7:0] t [256];
        logic [7:0] tmp, p;
        int i, j, f;
        t = m_s;
        i = 0;
        j = 0;
        exp_bytes = 0;
        exp_success = 1'b1;
        exp_fail = 0;
        for (int n = 0; n < len; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(t[i])) % 256;
            tmp = t[i];
            t[i] = t[j];
            t[j] = tmp;
            f = (int'(t[i]) + int'(t[j])) % 256;
            ks[n] = int'(t[f]);
            p = t[f] ^ k_rom[n];
            exp_a[n] = p;
            exp_bytes = n + 1;
            if (commit && CHK && !ok_char(int'(p))) begin
                exp_success = 1'b0;
                exp_fail = n;
                break;
            end
        end
        if (commit) m_s = t;
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        m_s = s_init;
    endtask

    // Leaves the bench inside cycle 1 (after the start-sampling edge).
    task automatic start_run(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        msg_len = 6'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, output int dc);
        dc = -1;
        for (int c = cyc0; c < cyc0 + 300; c++) begin
            @(negedge clk);
            if (done) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [43:0] outv;
        #2;
        outv = {busy, done, success, s_wren, a_wren, s_addr, s_wdata, k_addr, a_addr,
                a_wdata, fail_idx};
        total++;
        if (outv !== '0) $display("FAIL reset_outputs got %h want 0", outv);
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle busy=%b done=%b", busy, done);
        else passed++;
    endtask

    task automatic test_known_vector();
        int dc, a0;
        load_identity();
        k_rom[0] = 8'h63;
        k_rom[1] = 8'h64;
        a0 = a_wr_cnt;
        start_run(2);
        wait_done(1, dc);
        total++;
        if (dc !== 15) $display("FAIL known_latency got %0d want 15", dc); else passed++;
        total++;
        if (a_ram[0] !== 8'h61) $display("FAIL known_a0 got %h want 61", a_ram[0]); else passed++;
        total++;
        if (a_ram[1] !== 8'h61) $display("FAIL known_a1 got %h want 61", a_ram[1]); else passed++;
        total++;
        if (s_ram[2] !== 8'd3 || s_ram[3] !== 8'd2)
            $display("FAIL known_swap got S2=%h S3=%h want 03 02", s_ram[2], s_ram[3]);
        else passed++;
        total++;
        if (success !== 1'b1) $display("FAIL known_success got %b want 1", success); else passed++;
        total++;
        if (a_wr_cnt - a0 !== 2) $display("FAIL known_writes got %0d want 2", a_wr_cnt - a0);
        else passed++;
    endtask

    task automatic test_reject();
        int dc;
        load_identity();
        k_rom[0] = 8'h63;
        k_rom[1] = 8'h05;
        start_run(2);
        wait_done(1, dc);
        total++;
        if (dc !== 15) $display("FAIL reject_latency got %0d want 15", dc); else passed++;
        total++;
        if (a_ram[1] !== 8'h00) $display("FAIL reject_a1 got %h want 00", a_ram[1]); else passed++;
        total++;
        if (success !== !CHK) $display("FAIL reject_success got %b want %b", success, !CHK);
        else passed++;
        total++;
        if (fail_idx !== (CHK ? 5'd1 : 5'd0))
            $display("FAIL reject_fail_idx got %0d want %0d", fail_idx, CHK ? 1 : 0);
        else passed++;
    endtask

    task automatic test_zero_len();
        int dc, s0, a0;
        s0 = s_wr_cnt;
        a0 = a_wr_cnt;
        start_run(0);
        wait_done(1, dc);
        total++;
        if (dc !== 1) $display("FAIL zero_latency got %0d want 1", dc); else passed++;
        total++;
        if (success !== 1'b1 || fail_idx !== 5'd0)
            $display("FAIL zero_result got succ=%b idx=%0d want 1 0", success, fail_idx);
        else passed++;
        total++;
        if (s_wr_cnt != s0 || a_wr_cnt != a0)
            $display("FAIL zero_writes got s=%0d a=%0d want 0 0", s_wr_cnt - s0, a_wr_cnt - a0);
        else passed++;
    endtask

    task automatic test_abort();
        int s0, a0, d0;
        load_identity();
        k_rom[0] = 8'h63;
        k_rom[1] = 8'h64;
        s0 = s_wr_cnt;
        a0 = a_wr_cnt;
        start_run(2);
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(negedge clk);
        total++;
        if (s_wren !== 1'b0) $display("FAIL abort_wren_gated got %b want 0", s_wren); else passed++;
        @(posedge clk); #1;
        abort = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        repeat (30) @(negedge clk);
        total++;
        if (done_cnt != d0 || s_wr_cnt - s0 != 1 || a_wr_cnt != a0)
            $display("FAIL abort_quiet got done=%0d s=%0d a=%0d want 0 1 0",
                     done_cnt - d0, s_wr_cnt - s0, a_wr_cnt - a0);
        else passed++;
        total++;
        if (success !== 1'b0) $display("FAIL abort_success got %b want 0", success); else passed++;
    endtask

    task automatic test_abort_last_write();
        int a0, d0;
        load_identity();
        a0 = a_wr_cnt;
        d0 = done_cnt;
        start_run(2);
        repeat (13) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(negedge clk);
        total++;
        if (a_wren !== 1'b0) $display("FAIL abort_last_wren got %b want 0", a_wren); else passed++;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt != d0 || a_wr_cnt - a0 != 1 || success !== 1'b0)
            $display("FAIL abort_last got done=%0d a=%0d succ=%b want 0 1 0",
                     done_cnt - d0, a_wr_cnt - a0, success);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int dc, a0;
        load_identity();
        a0 = a_wr_cnt;
        start_run(2);
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b1;
            msg_len = 6'd1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, dc);
        total++;
        if (dc !== 15 || a_wr_cnt - a0 != 2)
            $display("FAIL restart_ignored got cyc=%0d writes=%0d want 15 2", dc, a_wr_cnt - a0);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [43:0] outv;
        int d0, busy_seen;
        load_identity();
        start_run(2);
        repeat (8) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        outv = {busy, done, success, s_wren, a_wren, s_addr, s_wdata, k_addr, a_addr,
                a_wdata, fail_idx};
        total++;
        if (outv !== '0) $display("FAIL midrun_reset got %h want 0", outv); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        total++;
        if (busy_seen != 0 || done_cnt != d0)
            $display("FAIL midrun_resume got busy=%0d done=%0d want 0 0", busy_seen, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_random();
        int dc, a0, len, bad;
        logic [7:0] ch;
        for (int x = 0; x < 256; x++) s_init[x] = 8'($urandom);
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        m_s = s_init;
        for (int r = 0; r < 10; r++) begin
            len = (r == 0) ? 32 : int'($urandom_range(1, 32));
            model_run(len, 1'b0);
            for (int n = 0; n < len; n++) begin
                ch = ($urandom_range(0, 7) == 0) ? 8'd32 : 8'($urandom_range(97, 122));
                k_rom[n] = 8'(ks[n]) ^ ch;
            end
            if ($urandom_range(0, 2) == 0) k_rom[$urandom_range(0, len - 1)] = 8'($urandom);
            model_run(len, 1'b1);
            a0 = a_wr_cnt;
            start_run(len);
            wait_done(1, dc);
            total++;
            if (dc !== 7 * exp_bytes + 1)
                $display("FAIL rand_latency run=%0d got %0d want %0d", r, dc, 7 * exp_bytes + 1);
            else passed++;
            total++;
            if (success !== exp_success || fail_idx !== (CHK ? 5'(exp_fail) : 5'd0))
                $display("FAIL rand_result run=%0d got succ=%b idx=%0d want %b %0d", r, success,
                         fail_idx, exp_success, CHK ? exp_fail : 0);
            else passed++;
            bad = -1;
            for (int n = exp_bytes - 1; n >= 0; n--) if (a_ram[n] !== exp_a[n]) bad = n;
            total++;
            if (bad >= 0 || a_wr_cnt - a0 != exp_bytes)
                $display("FAIL rand_answer run=%0d idx=%0d got %h want %h writes=%0d/%0d", r, bad,
                         a_ram[bad < 0 ? 0 : bad], exp_a[bad < 0 ? 0 : bad], a_wr_cnt - a0,
                         exp_bytes);
            else passed++;
            bad = -1;
            for (int x = 255; x >= 0; x--) if (s_ram[x] !== m_s[x]) bad = x;
            total++;
            if (bad >= 0)
                $display("FAIL rand_sbox run=%0d idx=%0d got %h want %h", r, bad, s_ram[bad],
                         m_s[bad]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_reject();
        test_zero_len();
        test_abort();
        test_abort_last_write();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
